rename_regfile: RTL and testbench

RENAME_REGFILE -- requirements
Module: rename_regfile

---
 rtl/rename_regfile.sv | 170 +++++++++++++++++
 tb/tb_rename_regfile.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rename_regfile.sv
// Architectural register file with rename busy/tag tracking, zero-latency operand lookup with ROB forwarding.
// Optional branch checkpoint (shadow busy/tag) built when RENAME_CKPT_EN is defined.
module rename_regfile #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 4,
    parameter int NRD   = 2
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             rdy_in,
    input  logic                             flush_in,
    input  logic [NRD*$clog2(NREG)-1:0]      rd_addr_i,
    output logic [NRD*XLEN-1:0]              rd_val_o,
    output logic [NRD-1:0]                   rd_busy_o,
    output logic [NRD*TAG_W-1:0]             rd_tag_o,
    input  logic [NRD-1:0]                   rob_ready_i,
    input  logic [NRD*XLEN-1:0]              rob_val_i,
    input  logic                             iss_valid_i,
    input  logic [$clog2(NREG)-1:0]          iss_rd_i,
    input  logic [TAG_W-1:0]                 iss_tag_i,
    input  logic                             cmt_valid_i,
    input  logic [$clog2(NREG)-1:0]          cmt_rd_i,
    input  logic [TAG_W-1:0]                 cmt_tag_i,
    input  logic [XLEN-1:0]                  cmt_val_i,
    input  logic                             ckpt_save_i,
    input  logic                             ckpt_restore_i,
    output logic                             ckpt_valid_o
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]  val_q [NREG];
    logic [XLEN-1:0]  val_d [NREG];
    logic [NREG-1:0]  busy_q, busy_d, norm_busy;
    logic [TAG_W-1:0] tag_q [NREG];
    logic [TAG_W-1:0] tag_d [NREG];
    logic [TAG_W-1:0] norm_tag [NREG];

`ifdef RENAME_CKPT_EN
    logic [NREG-1:0]  sbusy_q, sbusy_d, sh_busy;
    logic [TAG_W-1:0] stag_q [NREG];
    logic [TAG_W-1:0] stag_d [NREG];
    logic [TAG_W-1:0] sh_tag [NREG];
    logic             ckpt_q, ckpt_d;
    assign ckpt_valid_o = ckpt_q;
`else
    logic unused_save;
    assign unused_save  = ckpt_save_i;
    assign ckpt_valid_o = 1'b0;
`endif

    // Normal-path update: commit clears only a matching tag, issue always wins.
    always_comb begin
        val_d     = val_q;
        norm_busy = busy_q;
        norm_tag  = tag_q;
`ifdef RENAME_CKPT_EN
        sh_busy   = sbusy_q;
        sh_tag    = stag_q;
`endif
        for (int r = 1; r < NREG; r++) begin
            if (cmt_valid_i && cmt_rd_i == AW'(r)) begin
                val_d[r] = cmt_val_i;
                if (tag_q[r] == cmt_tag_i && !(iss_valid_i && iss_rd_i == AW'(r))) begin
                    norm_busy[r] = 1'b0;
                    norm_tag[r]  = '0;
                end
`ifdef RENAME_CKPT_EN
                if (stag_q[r] == cmt_tag_i) begin
                    sh_busy[r] = 1'b0;
                    sh_tag[r]  = '0;
                end
`endif
            end
            if (iss_valid_i && iss_rd_i == AW'(r)) begin
                norm_busy[r] = 1'b1;
                norm_tag[r]  = iss_tag_i;
            end
        end
    end

    always_comb begin
        busy_d = norm_busy;
        tag_d  = norm_tag;
`ifdef RENAME_CKPT_EN
        sbusy_d = sh_busy;
        stag_d  = sh_tag;
        ckpt_d  = ckpt_q;
        if (flush_in || (ckpt_restore_i && !ckpt_q)) begin
            busy_d  = '0;
            sbusy_d = '0;
            ckpt_d  = 1'b0;
            for (int r = 0; r < NREG; r++) begin
                tag_d[r]  = '0;
                stag_d[r] = '0;
            end
        end else if (ckpt_restore_i) begin
            busy_d = sh_busy;
            tag_d  = sh_tag;
            ckpt_d = 1'b0;
        end else if (ckpt_save_i) begin
            sbusy_d = norm_busy;
            stag_d  = norm_tag;
            ckpt_d  = 1'b1;
        end
`else
        if (flush_in || ckpt_restore_i) begin
            busy_d = '0;
            for (int r = 0; r < NREG; r++) tag_d[r] = '0;
        end
`endif
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                val_q[r] <= '0;
                tag_q[r] <= '0;
            end
`ifdef RENAME_CKPT_EN
            sbusy_q <= '0;
            ckpt_q  <= 1'b0;
            for (int r = 0; r < NREG; r++) stag_q[r] <= '0;
`endif
        end else if (rdy_in) begin
            busy_q <= busy_d;
            val_q  <= val_d;
            tag_q  <= tag_d;
`ifdef RENAME_CKPT_EN
            sbusy_q <= sbusy_d;
            stag_q  <= stag_d;
            ckpt_q  <= ckpt_d;
`endif
        end
    end

    // Lookup priority: x0, same-cycle issue, same-cycle matching commit, stored state.
    for (genvar k = 0; k < NRD; k++) begin : g_port
        logic [AW-1:0]    a;
        logic             pend;
        logic [TAG_W-1:0] tg;
        logic [XLEN-1:0]  v;

        assign a = rd_addr_i[k*AW +: AW];

        always_comb begin
            pend = 1'b0;
            tg   = '0;
            v    = '0;
            if (a != '0) begin
                if (iss_valid_i && iss_rd_i == a) begin
                    pend = 1'b1;
                    tg   = iss_tag_i;
                end else if (cmt_valid_i && cmt_rd_i == a && busy_q[a] && tag_q[a] == cmt_tag_i) begin
                    v  = cmt_val_i;
                    tg = tag_q[a];
                end else begin
                    pend = busy_q[a];
                    tg   = tag_q[a];
                    v    = val_q[a];
                end
            end
        end

        assign rd_busy_o[k]                = pend & ~rob_ready_i[k];
        assign rd_tag_o[k*TAG_W +: TAG_W]  = tg;
        assign rd_val_o[k*XLEN +: XLEN]    = pend ? rob_val_i[k*XLEN +: XLEN] : v;
    end
endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: lookup bypass, issue/commit ordering, flush, hold, reset, checkpoint.
module tb_rename_regfile;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic [9:0]  rd_addr_i;
    logic [63:0] rd_val_o;
    logic [1:0]  rd_busy_o;
    logic [7:0]  rd_tag_o;
    logic [1:0]  rob_ready_i;
    logic [63:0] rob_val_i;
    logic        iss_valid_i;
    logic [4:0]  iss_rd_i;
    logic [3:0]  iss_tag_i;
    logic        cmt_valid_i;
    logic [4:0]  cmt_rd_i;
    logic [3:0]  cmt_tag_i;
    logic [31:0] cmt_val_i;
    logic        ckpt_save_i, ckpt_restore_i, ckpt_valid_o;

    int checks   = 0;
    int failures = 0;
    logic ck_exp;

    rename_regfile dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .rd_addr_i(rd_addr_i), .rd_val_o(rd_val_o), .rd_busy_o(rd_busy_o), .rd_tag_o(rd_tag_o),
        .rob_ready_i(rob_ready_i), .rob_val_i(rob_val_i),
        .iss_valid_i(iss_valid_i), .iss_rd_i(iss_rd_i), .iss_tag_i(iss_tag_i),
        .cmt_valid_i(cmt_valid_i), .cmt_rd_i(cmt_rd_i), .cmt_tag_i(cmt_tag_i), .cmt_val_i(cmt_val_i),
        .ckpt_save_i(ckpt_save_i), .ckpt_restore_i(ckpt_restore_i), .ckpt_valid_o(ckpt_valid_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        flush_in = 0; rob_ready_i = 0; rob_val_i = 0;
        iss_valid_i = 0; iss_rd_i = 0; iss_tag_i = 0;
        cmt_valid_i = 0; cmt_rd_i = 0; cmt_tag_i = 0; cmt_val_i = 0;
        ckpt_save_i = 0; ckpt_restore_i = 0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic look(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr_i = {a1, a0};
        #1;
    endtask

    task automatic issue(input logic [4:0] r, input logic [3:0] t);
        iss_valid_i = 1; iss_rd_i = r; iss_tag_i = t;
    endtask

    task automatic commit(input logic [4:0] r, input logic [3:0] t, input logic [31:0] v);
        cmt_valid_i = 1; cmt_rd_i = r; cmt_tag_i = t; cmt_val_i = v;
    endtask

    initial begin
`ifdef RENAME_CKPT_EN
        ck_exp = 1'b1;
`else
        ck_exp = 1'b0;
`endif
        rst_in = 1; rdy_in = 1; rd_addr_i = 0;
        idle();
        look(5'd5, 5'd0);
        chk("rst_val", {32'h0, rd_val_o[31:0]}, 64'h0);
        chk("rst_busy", {62'h0, rd_busy_o}, 64'h0);
        chk("rst_tag", {56'h0, rd_tag_o}, 64'h0);
        chk("rst_ckpt", {63'h0, ckpt_valid_o}, 64'h0);
        #6 rst_in = 0;
        tick();

        // issue x5 tag 3, same-cycle and next-cycle lookup
        issue(5'd5, 4'd3);
        look(5'd0, 5'd5);
        chk("iss_bypass_busy", {63'h0, rd_busy_o[1]}, 64'h1);
        chk("iss_bypass_tag", {60'h0, rd_tag_o[7:4]}, 64'h3);
        tick(); idle();
        look(5'd5, 5'd6);
        chk("x5_busy", {63'h0, rd_busy_o[0]}, 64'h1);
        chk("x5_tag", {60'h0, rd_tag_o[3:0]}, 64'h3);
        chk("x6_idle_busy", {63'h0, rd_busy_o[1]}, 64'h0);
        rob_ready_i = 2'b01; rob_val_i = {32'h0, 32'h55};
        #1;
        chk("x5_rob_busy", {63'h0, rd_busy_o[0]}, 64'h0);
        chk("x5_rob_val", {32'h0, rd_val_o[31:0]}, 64'h55);

        // stale commit (tag mismatch) keeps x5 busy
        idle(); commit(5'd5, 4'd9, 32'h77);
        tick(); idle();
        look(5'd5, 5'd0);
        chk("stale_cmt_busy", {63'h0, rd_busy_o[0]}, 64'h1);
        chk("stale_cmt_tag", {60'h0, rd_tag_o[3:0]}, 64'h3);

        // issue and commit same register same cycle: issue wins
        issue(5'd7, 4'd2); commit(5'd7, 4'd1, 32'd9);
        tick(); idle();
        rob_val_i = {32'h0, 32'h1234};
        look(5'd7, 5'd0);
        chk("x7_busy", {63'h0, rd_busy_o[0]}, 64'h1);
        chk("x7_tag", {60'h0, rd_tag_o[3:0]}, 64'h2);
        chk("x7_pend_val", {32'h0, rd_val_o[31:0]}, 64'h1234);

        // commit bypass on matching tag
        idle(); issue(5'd4, 4'd6);
        tick(); idle();
        commit(5'd4, 4'd6, 32'hAB);
        look(5'd4, 5'd0);
        chk("cmt_bypass_busy", {63'h0, rd_busy_o[0]}, 64'h0);
        chk("cmt_bypass_val", {32'h0, rd_val_o[31:0]}, 64'hAB);
        tick(); idle();
        look(5'd4, 5'd0);
        chk("x4_after_busy", {63'h0, rd_busy_o[0]}, 64'h0);
        chk("x4_after_val", {32'h0, rd_val_o[31:0]}, 64'hAB);

        // register 0 is immune
        issue(5'd0, 4'd5); commit(5'd0, 4'd0, 32'hFF);
        rob_ready_i = 2'b11; rob_val_i = {32'hEE, 32'hEE};
        look(5'd0, 5'd0);
        chk("x0_same_val", {32'h0, rd_val_o[31:0]}, 64'h0);
        chk("x0_same_busy", {62'h0, rd_busy_o}, 64'h0);
        chk("x0_same_tag", {56'h0, rd_tag_o}, 64'h0);
        tick(); idle();
        look(5'd0, 5'd0);
        chk("x0_after_val", rd_val_o, 64'h0);
        chk("x0_after_tag", {56'h0, rd_tag_o}, 64'h0);

        // flush with commit value and ignored issue
        issue(5'd8, 4'd1); tick();
        issue(5'd9, 4'd2); tick(); idle();
        flush_in = 1; commit(5'd8, 4'd0, 32'd7); issue(5'd10, 4'd4);
        tick(); idle();
        look(5'd8, 5'd9);
        chk("flush_x8_busy", {63'h0, rd_busy_o[0]}, 64'h0);
        chk("flush_x8_val", {32'h0, rd_val_o[31:0]}, 64'h7);
        chk("flush_x9_busy", {63'h0, rd_busy_o[1]}, 64'h0);
        look(5'd10, 5'd5);
        chk("flush_x10_x5_busy", {62'h0, rd_busy_o}, 64'h0);
        look(5'd7, 5'd0);
        chk("flush_x7_val", {32'h0, rd_val_o[31:0]}, 64'h9);

        // hold with rdy low
        issue(5'd12, 4'd3); tick(); idle();
        rdy_in = 0; issue(5'd13, 4'd1); commit(5'd12, 4'd3, 32'h42);
        flush_in = 1; ckpt_restore_i = 1;
        tick(); idle(); rdy_in = 1;
        look(5'd12, 5'd13);
        chk("hold_x12_busy", {63'h0, rd_busy_o[0]}, 64'h1);
        chk("hold_x12_tag", {60'h0, rd_tag_o[3:0]}, 64'h3);
        chk("hold_x13_busy", {63'h0, rd_busy_o[1]}, 64'h0);
        chk("hold_x13_val", {32'h0, rd_val_o[63:32]}, 64'h0);

        // asynchronous reset pulse between edges
        look(5'd12, 5'd8);
        #2 rst_in = 1;
        #1;
        chk("async_rst_busy", {62'h0, rd_busy_o}, 64'h0);
        chk("async_rst_tag", {56'h0, rd_tag_o}, 64'h0);
        chk("async_rst_x8_val", {32'h0, rd_val_o[63:32]}, 64'h0);
        #1 rst_in = 0;
        tick();

        // checkpoint save / commit to shadow / restore
        issue(5'd3, 4'd1); tick(); idle();
        ckpt_save_i = 1; tick(); idle();
        chk("save_ckpt_valid", {63'h0, ckpt_valid_o}, {63'h0, ck_exp});
        issue(5'd3, 4'd2); tick(); idle();
        commit(5'd3, 4'd1, 32'h33);
        look(5'd3, 5'd0);
        chk("x3_cmt_old_busy", {63'h0, rd_busy_o[0]}, 64'h1);
        chk("x3_cmt_old_tag", {60'h0, rd_tag_o[3:0]}, 64'h2);
        tick(); idle();
        ckpt_restore_i = 1; tick(); idle();
        look(5'd3, 5'd0);
        chk("restore_x3_busy", {63'h0, rd_busy_o[0]}, 64'h0);
        chk("restore_ckpt_valid", {63'h0, ckpt_valid_o}, 64'h0);

        // restore with concurrent save: restore taken, save dropped
        issue(5'd10, 4'd5); tick(); idle();
        ckpt_save_i = 1; tick(); idle();
        issue(5'd11, 4'd6); tick(); idle();
        ckpt_restore_i = 1; ckpt_save_i = 1; tick(); idle();
        look(5'd10, 5'd11);
        chk("rs_x10_busy", {63'h0, rd_busy_o[0]}, {63'h0, ck_exp});
        chk("rs_x10_tag", {60'h0, rd_tag_o[3:0]}, ck_exp ? 64'h5 : 64'h0);
        chk("rs_x11_busy", {63'h0, rd_busy_o[1]}, 64'h0);
        chk("rs_ckpt_valid", {63'h0, ckpt_valid_o}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
